// File: rtl/checkbits_monitor.sv
// checkbits_monitor: steps GPIO checkbits through a programmed code sequence with a per-stage timeout
// Ports: wb_clk_i clock, wb_rst_i async reset; start_i arms; checkbits_i raw GPIO; expect_i stage codes
// (stage k at [k*WIDTH +: WIDTH]); timeout_i per-stage limit (0 = none); fail_code_i abort code;
// busy_o/done_o/pass_o/fail_o/timed_out_o status; stage_o stages matched; last_code_o last qualified code.
// Define CHECKBITS_FAIL_CODE_EN to let a qualified fail_code_i end the sequence.
module checkbits_monitor #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4,
  parameter int TIMEOUT_W = 24,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           start_i,
  input  logic [WIDTH-1:0]               checkbits_i,
  input  logic [STAGES*WIDTH-1:0]        expect_i,
  input  logic [TIMEOUT_W-1:0]           timeout_i,
  input  logic [WIDTH-1:0]               fail_code_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           fail_o,
  output logic                           timed_out_o,
  output logic [$clog2(STAGES+1)-1:0]    stage_o,
  output logic [WIDTH-1:0]               last_code_o
);
  localparam int SW = $clog2(STAGES + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SB = SYNC_STAGES * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync, sync_nxt;
  logic [WIDTH-1:0] s, exp_code;
  logic [CW-1:0] stable_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic qual, match, fail_hit, tmo_hit, last_stage;
  assign sync_nxt = SB'({sync, checkbits_i});
  assign s = sync[SYNC_STAGES-1];
  // stable_cnt saturates one past the threshold so each stable run qualifies exactly once
  assign qual = stable_cnt == CW'(STABLE_CYCLES - 1);
  assign exp_code = expect_i[stage_o*WIDTH +: WIDTH];
  assign match = qual && s == exp_code;
  assign last_stage = stage_o == SW'(STAGES - 1);
  assign tmo_hit = timeout_i != '0 && tmo_cnt == timeout_i - 1'b1;
`ifdef CHECKBITS_FAIL_CODE_EN
  assign fail_hit = qual && s == fail_code_i;
`else
  logic unused_fail_code;
  assign unused_fail_code = ^fail_code_i;
  assign fail_hit = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      sync <= '0;
      stable_cnt <= '0;
      tmo_cnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      fail_o <= 1'b0;
      timed_out_o <= 1'b0;
      stage_o <= '0;
      last_code_o <= '0;
    end else begin
      sync <= sync_nxt;
      stable_cnt <= sync_nxt[SYNC_STAGES-1] != s ? '0 : stable_cnt + CW'(stable_cnt != CW'(STABLE_CYCLES));
      if (qual) last_code_o <= s;
      if (state == RUN) begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(~&tmo_cnt);
        if (fail_hit) begin
          fail_o <= 1'b1;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= DONE;
        end else if (match) begin
          stage_o <= stage_o + 1'b1;
          tmo_cnt <= '0;
          if (last_stage) begin
            pass_o <= 1'b1;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state <= DONE;
          end
        end else if (tmo_hit) begin
          timed_out_o <= 1'b1;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= DONE;
        end
      end else if (start_i) begin
        state <= RUN;
        busy_o <= 1'b1;
        stage_o <= '0;
        tmo_cnt <= '0;
        done_o <= 1'b0;
        pass_o <= 1'b0;
        fail_o <= 1'b0;
        timed_out_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_checkbits_monitor.sv
// tb_checkbits_monitor: directed and random checks of checkbits_monitor against a sample-history model
module tb_checkbits_monitor;
  localparam int W = 16, ST = 2, TW = 24, SS = 2, SC = 4, SWD = $clog2(ST + 1);
`ifdef CHECKBITS_FAIL_CODE_EN
  localparam bit FAIL_EN = 1'b1;
`else
  localparam bit FAIL_EN = 1'b0;
`endif
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b0, start_i = 1'b0;
  logic [W-1:0] checkbits_i = '0, fail_code_i = 16'hdead;
  logic [ST*W-1:0] expect_i = {16'h00d6, 16'h00d5};
  logic [TW-1:0] timeout_i = 24'd1000;
  logic busy_o, done_o, pass_o, fail_o, timed_out_o;
  logic [SWD-1:0] stage_o;
  logic [W-1:0] last_code_o;
  int compared = 0, mismatched = 0;
  int q[$];
  int m_state = 0, m_stage = 0, m_cyc = 0;
  bit m_busy = 0, m_done = 0, m_pass = 0, m_fail = 0, m_to = 0;
  logic [W-1:0] m_last = '0;
  logic [W-1:0] codes [4] = '{16'h00d5, 16'h00d6, 16'h0000, 16'hdead};
  checkbits_monitor #(.WIDTH(W), .STAGES(ST), .TIMEOUT_W(TW), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .checkbits_i(checkbits_i),
    .expect_i(expect_i), .timeout_i(timeout_i), .fail_code_i(fail_code_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timed_out_o(timed_out_o),
    .stage_o(stage_o), .last_code_o(last_code_o));
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: q[0] is the newest input sample; the synchronised value is q[SS-1] and it
  // qualifies when its run of equal samples is exactly SC long (-1 marks the reset boundary).
  always @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      q.delete();
      for (int i = 0; i < SS; i++) q.push_back(0);
      q.push_back(-1);
      m_state = 0; m_stage = 0; m_cyc = 0;
      {m_busy, m_done, m_pass, m_fail, m_to} = '0;
      m_last = '0;
    end else begin : step
      int s, run;
      bit qual;
      s = q[SS-1];
      run = 0;
      for (int i = SS - 1; i < q.size() && q[i] == s; i++) run++;
      qual = run == SC;
      if (m_state == 1) begin
        m_cyc++;
        if (FAIL_EN && qual && s == int'(fail_code_i)) begin
          m_fail = 1; m_done = 1; m_busy = 0; m_state = 2;
        end else if (qual && s == int'(expect_i[m_stage*W +: W])) begin
          m_stage++; m_cyc = 0;
          if (m_stage == ST) begin m_pass = 1; m_done = 1; m_busy = 0; m_state = 2; end
        end else if (timeout_i != 0 && m_cyc == int'(timeout_i)) begin
          m_to = 1; m_done = 1; m_busy = 0; m_state = 2;
        end
      end else if (start_i) begin
        m_state = 1; m_busy = 1; m_stage = 0; m_cyc = 0;
        {m_done, m_pass, m_fail, m_to} = '0;
      end
      if (qual) m_last = W'(s);
      q.push_front(int'(checkbits_i));
      while (q.size() > SS + SC + 1) void'(q.pop_back());
    end
  always @(negedge wb_clk_i) begin
    check("m_busy", busy_o, m_busy);
    check("m_done", done_o, m_done);
    check("m_pass", pass_o, m_pass);
    check("m_fail", fail_o, m_fail);
    check("m_timeout", timed_out_o, m_to);
    check("m_stage", stage_o, m_stage);
    check("m_last", last_code_o, m_last);
  end
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge wb_clk_i) start_i = 1'b0;
  endtask
  task automatic advance(input string tag, input int exp_stage);
    repeat (SS + SC - 1) @(posedge wb_clk_i);
    #1 check({tag, "_early"}, stage_o, exp_stage - 1);
    @(posedge wb_clk_i);
    #1 check(tag, stage_o, exp_stage);
    @(negedge wb_clk_i);
  endtask
  initial begin
    int hold = 0;
    #1 wb_rst_i = 1'b1;
    #1 check("reset_outs", {busy_o, done_o, pass_o, fail_o, timed_out_o, stage_o, last_code_o}, 0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    pulse_start();
    check("start_busy", busy_o, 1);
    checkbits_i = 16'h00d5;
    advance("nom_stage1", 1);
    checkbits_i = 16'h00d6;
    advance("nom_stage2", 2);
    check("nom_pass", pass_o, 1);
    check("nom_done", done_o, 1);
    check("nom_timeout", timed_out_o, 0);
    check("nom_last", last_code_o, 16'h00d6);
    pulse_start();
    check("rearm_flags", {busy_o, done_o, pass_o, stage_o}, 5'b10000);
    checkbits_i = 16'h00d5;
    repeat (3) @(negedge wb_clk_i);
    checkbits_i = 16'h0000;
    repeat (20) @(negedge wb_clk_i);
    check("glitch_stage", stage_o, 0);
    checkbits_i = 16'h00d5;
    advance("glitch_stage1", 1);
    pulse_start();
    check("run_start_busy", busy_o, 1);
    check("run_start_stage", stage_o, 1);
    checkbits_i = 16'h00d6;
    advance("restart_stage2", 2);
    checkbits_i = 16'h0000;
    timeout_i = 24'd100;
    start_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i) start_i = 1'b0;
    repeat (99) @(posedge wb_clk_i);
    #1 check("tmo_early", {timed_out_o, busy_o}, 2'b01);
    @(posedge wb_clk_i);
    #1 check("tmo_fire", {timed_out_o, done_o, pass_o, busy_o}, 4'b1100);
    @(negedge wb_clk_i) timeout_i = '0;
    pulse_start();
    repeat (10000) @(negedge wb_clk_i);
    check("tmo0_busy", {busy_o, done_o, timed_out_o}, 3'b100);
    checkbits_i = 16'hdead;
    repeat (SS + SC + 2) @(negedge wb_clk_i);
    check("failcode_fail", fail_o, FAIL_EN);
    check("failcode_done", done_o, FAIL_EN);
    check("failcode_busy", busy_o, !FAIL_EN);
    check("failcode_pass", pass_o, 0);
    timeout_i = 24'd1000;
    pulse_start();
    checkbits_i = 16'h00d5;
    advance("mid_stage1", 1);
    #3 wb_rst_i = 1'b1;
    #1 check("async_reset", {busy_o, done_o, pass_o, fail_o, timed_out_o, stage_o, last_code_o}, 0);
    @(negedge wb_clk_i) checkbits_i = 16'h0000;
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    pulse_start();
    check("post_reset_stage", stage_o, 0);
    checkbits_i = 16'h00d5;
    advance("post_reset_stage1", 1);
    checkbits_i = 16'h00d6;
    advance("post_reset_stage2", 2);
    check("post_reset_pass", pass_o, 1);
    checkbits_i = 16'h0000;
    timeout_i = 24'd5;
    repeat (10) @(negedge wb_clk_i);
    start_i = 1'b1;
    checkbits_i = 16'h00d5;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i) start_i = 1'b0;
    repeat (5) @(posedge wb_clk_i);
    #1 check("simul_advance", {stage_o, timed_out_o, busy_o}, 4'b0101);
    repeat (5) @(posedge wb_clk_i);
    #1 check("simul_next_tmo", {stage_o, timed_out_o, done_o}, 4'b0111);
    for (int c = 0; c < 20000; c++) begin
      @(negedge wb_clk_i);
      start_i = $urandom_range(0, 39) == 0;
      if (start_i) begin
        expect_i = {codes[$urandom_range(0, 3)], codes[$urandom_range(0, 3)]};
        timeout_i = $urandom_range(0, 3) == 0 ? '0 : TW'($urandom_range(1, 150));
      end
      if (hold == 0) begin
        checkbits_i = $urandom_range(0, 4) == 0 ? W'($urandom) : codes[$urandom_range(0, 3)];
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 1999) == 0) begin
        #2 wb_rst_i = 1'b1;
        @(negedge wb_clk_i) wb_rst_i = 1'b0;
      end
    end
    @(negedge wb_clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
